// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/freeze controller with mem-wait timeout and halt
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rd,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             memRead_EX,
  input  logic             regWrite_EX,
  input  logic             memRead_MEM,
  input  logic             memWrite_MEM,
  input  logic             mem_ready,
  input  logic             branchTaken_MEM,
  input  logic             halt_WB,
  input  logic             resume,
  output logic             pcWrite,
  output logic             ifidEnable,
  output logic             idexEnable,
  output logic             exmemEnable,
  output logic             memwbEnable,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             halted,
  output logic             memError,
  output logic [CNT_W-1:0] stallCycles
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2,
    S_HALT       = 2'd3
  } state_t;

  // MEM_TIMEOUT is at most 255, so an 8-bit wait counter never wraps before the error fires
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [7:0]       wait_inc;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_busy;
  logic             load_use;

  // Hazard detection terms
  always_comb begin
    mem_busy = (memRead_MEM | memWrite_MEM) & ~mem_ready;
    load_use = memRead_EX & regWrite_EX &
               ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rd & (id_rd == ex_dest)));
    wait_inc = wait_cnt_q + 8'd1;
  end

  // Next-state and Mealy control outputs, highest-priority event first
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    mem_error_d = mem_error_q;
    pcWrite     = 1'b1;
    ifidEnable  = 1'b1;
    idexEnable  = 1'b1;
    exmemEnable = 1'b1;
    memwbEnable = 1'b1;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    exmemFlush  = 1'b0;
    halted      = 1'b0;

    if (state_q == S_HALT) begin
      pcWrite     = 1'b0;
      ifidEnable  = 1'b0;
      idexEnable  = 1'b0;
      exmemEnable = 1'b0;
      memwbEnable = 1'b0;
      halted      = 1'b1;
      // A memory timeout is fatal until reset; resume cannot restart the core
      if (resume && !mem_error_q) begin
        state_d = S_RUN;
      end
    end else if (mem_busy) begin
      pcWrite     = 1'b0;
      ifidEnable  = 1'b0;
      idexEnable  = 1'b0;
      exmemEnable = 1'b0;
      memwbEnable = 1'b0;
      wait_cnt_d  = wait_inc;
      if (wait_inc == TIMEOUT) begin
        mem_error_d = 1'b1;
        state_d     = S_HALT;
      end else begin
        state_d = S_MEM_WAIT;
      end
    end else if (branchTaken_MEM) begin
      // Squash the three younger instructions; a pending load-use bubble is moot
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
      state_d    = S_RUN;
    end else if (halt_WB) begin
      // Let HLT retire through MEM/WB while everything behind it holds
      pcWrite     = 1'b0;
      ifidEnable  = 1'b0;
      idexEnable  = 1'b0;
      exmemEnable = 1'b0;
      state_d     = S_HALT;
    end else if (load_use && (state_q != S_LOAD_STALL)) begin
      // Hold PC and IF/ID, insert a bubble into ID/EX
      pcWrite    = 1'b0;
      ifidEnable = 1'b0;
      idexFlush  = 1'b1;
      state_d    = S_LOAD_STALL;
    end else begin
      state_d = S_RUN;
    end

    if (reset) begin
      pcWrite     = 1'b0;
      ifidEnable  = 1'b0;
      idexEnable  = 1'b0;
      exmemEnable = 1'b0;
      memwbEnable = 1'b0;
      ifidFlush   = 1'b0;
      idexFlush   = 1'b0;
      exmemFlush  = 1'b0;
      halted      = 1'b0;
    end
  end

  // State, wait counter and sticky error registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Saturating count of non-halt cycles in which the PC did not advance
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!pcWrite && (state_q != S_HALT) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign memError    = mem_error_q;
  assign stallCycles = stall_cnt_q;

endmodule
